// File: rtl/boot_sequencer.sv
// Boot controller: holds the core in reset, writes the boot address over the
// req/gnt config bus, enables fetch and waits for end-of-computation or timeout.
module boot_sequencer #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter logic [31:0] CFG_ADDR  = 32'h1A10_7008,
  parameter int          RST_DLY   = 50,
  parameter int          START_DLY = 20,
  parameter int          TIMEOUT_W = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  input  logic                 eoc_i,
  output logic                 core_rst_o,
  output logic                 fetch_enable_o,
  output logic                 cfg_req_o,
  output logic [31:0]          cfg_addr_o,
  output logic [31:0]          cfg_wdata_o,
  input  logic                 cfg_gnt_i,
  input  logic                 cfg_rvalid_i,
  input  logic                 cfg_err_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [1:0]           status_o,
  output logic [31:0]          cycles_o
);

  localparam int DLY_MAX = (RST_DLY > START_DLY) ? RST_DLY : START_DLY;
  localparam int CNT_W   = $clog2(DLY_MAX + 1);
  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_DLY - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_DLY - 1);

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_PASS = 2'b01;
  localparam logic [1:0] ST_CERR = 2'b10;
  localparam logic [1:0] ST_TOUT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_RST_WAIT, S_CFG_REQ, S_CFG_RSP, S_START_WAIT, S_RUN, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_pend_q, abort_pend_d;
  logic [1:0]       status_q, status_d;
  logic [31:0]      cycles_q, cycles_d;
  logic             done_q, done_d;
  logic             eoc_s1_q, eoc_s1_d;
  logic             eoc_s2_q, eoc_s2_d;
  logic             timeout_hit;

  assign timeout_hit = (timeout_i != '0) &&
                       (cycles_q[TIMEOUT_W-1:0] == timeout_i - TIMEOUT_W'(1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    abort_pend_d = abort_pend_q;
    status_d     = status_q;
    cycles_d     = cycles_q;
    eoc_s1_d     = eoc_i;
    eoc_s2_d     = eoc_s1_q;
    case (state_q)
      S_IDLE: begin
        abort_pend_d = 1'b0;
        if (start_i && !abort_i) begin
          state_d  = S_RST_WAIT;
          status_d = ST_NONE;
          cycles_d = '0;
        end
      end
      S_RST_WAIT: begin
        if (abort_i) begin
          state_d  = S_IDLE;
          status_d = ST_NONE;
        end else if (cnt_q == RST_LAST) begin
          state_d = S_CFG_REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CFG_REQ: begin
        // The bus transaction must complete, so abort is only remembered here.
        if (abort_i) abort_pend_d = 1'b1;
        if (cfg_gnt_i) state_d = S_CFG_RSP;
      end
      S_CFG_RSP: begin
        if (abort_i) abort_pend_d = 1'b1;
        if (cfg_rvalid_i) begin
          abort_pend_d = 1'b0;
          if (abort_pend_q || abort_i) begin
            state_d  = S_IDLE;
            status_d = ST_NONE;
          end else if (cfg_err_i) begin
            state_d  = S_DONE;
            status_d = ST_CERR;
          end else begin
            state_d = S_START_WAIT;
          end
        end
      end
      S_START_WAIT: begin
        if (abort_i) begin
          state_d  = S_IDLE;
          status_d = ST_NONE;
        end else if (cnt_q == START_LAST) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (abort_i) begin
          state_d  = S_IDLE;
          status_d = ST_NONE;
        end else begin
          cycles_d = (cycles_q == '1) ? cycles_q : cycles_q + 32'd1;
          if (eoc_s2_q) begin
            state_d  = S_DONE;
            status_d = ST_PASS;
          end else if (timeout_hit) begin
            state_d  = S_DONE;
            status_d = ST_TOUT;
          end
        end
      end
      S_DONE: begin
        if (abort_i) begin
          state_d  = S_IDLE;
          status_d = ST_NONE;
        end else if (start_i) begin
          state_d  = S_RST_WAIT;
          status_d = ST_NONE;
          cycles_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    done_d = (state_d == S_DONE) && (state_q != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      abort_pend_q <= 1'b0;
      status_q     <= ST_NONE;
      cycles_q     <= '0;
      done_q       <= 1'b0;
      eoc_s1_q     <= 1'b0;
      eoc_s2_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      abort_pend_q <= abort_pend_d;
      status_q     <= status_d;
      cycles_q     <= cycles_d;
      done_q       <= done_d;
      eoc_s1_q     <= eoc_s1_d;
      eoc_s2_q     <= eoc_s2_d;
    end
  end

  assign core_rst_o     = (state_q == S_IDLE) || (state_q == S_RST_WAIT);
  assign fetch_enable_o = (state_q == S_RUN);
  assign cfg_req_o      = (state_q == S_CFG_REQ);
  assign cfg_addr_o     = cfg_req_o ? CFG_ADDR : 32'h0;
  assign cfg_wdata_o    = cfg_req_o ? BOOT_ADDR : 32'h0;
  assign busy_o         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o         = done_q;
  assign status_o       = status_q;
  assign cycles_o       = cycles_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer; done_o events are checked against a
// queue of expected {status, cycles} by an independent monitor.
module tb_boot_sequencer;

  typedef struct packed {
    logic [1:0]  st;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0, abort_i = 1'b0, eoc_i = 1'b0;
  logic        cfg_gnt_i = 1'b0, cfg_rvalid_i = 1'b0, cfg_err_i = 1'b0;
  logic [23:0] timeout_i = '0;
  logic        core_rst_o, fetch_enable_o, cfg_req_o, busy_o, done_o;
  logic [31:0] cfg_addr_o, cfg_wdata_o, cycles_o;
  logic [1:0]  status_o;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic chk_low = 1'b0;

  boot_sequencer dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .timeout_i(timeout_i), .eoc_i(eoc_i),
    .core_rst_o(core_rst_o), .fetch_enable_o(fetch_enable_o),
    .cfg_req_o(cfg_req_o), .cfg_addr_o(cfg_addr_o), .cfg_wdata_o(cfg_wdata_o),
    .cfg_gnt_i(cfg_gnt_i), .cfg_rvalid_i(cfg_rvalid_i), .cfg_err_i(cfg_err_i),
    .busy_o(busy_o), .done_o(done_o), .status_o(status_o), .cycles_o(cycles_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Monitor: every done_o pulse consumes one expected result.
  always @(negedge clk) begin
    if (chk_low) begin
      chk("done_one_pulse", {31'd0, done_o}, 32'd0);
      chk_low = 1'b0;
    end
    if (!rst && done_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_status", {30'd0, status_o}, {30'd0, e.st});
        chk("done_cycles", cycles_o, e.cyc);
      end
      chk_low = 1'b1;
    end
  end

  task automatic start_and_cfg(input logic err, input int gnt_dly, input bit abort_in_req);
    int n;
    start_i = 1'b1; tick(); start_i = 1'b0;
    n = 0;
    while (!cfg_req_o && n < 1000) begin
      if (core_rst_o) n++;
      tick();
    end
    chk("rst_wait_len", n, 50);
    chk("cfg_addr", cfg_addr_o, 32'h1A10_7008);
    chk("cfg_wdata", cfg_wdata_o, 32'h0);
    chk("core_rst_low_in_req", {31'd0, core_rst_o}, 32'd0);
    if (abort_in_req) begin
      abort_i = 1'b1; tick(); abort_i = 1'b0;
    end
    repeat (gnt_dly) tick();
    chk("req_held", {31'd0, cfg_req_o}, 32'd1);
    cfg_gnt_i = 1'b1; tick(); cfg_gnt_i = 1'b0;
    chk("req_drop", {31'd0, cfg_req_o}, 32'd0);
    chk("addr_zero_idle", cfg_addr_o, 32'h0);
    cfg_rvalid_i = 1'b1; cfg_err_i = err; tick();
    cfg_rvalid_i = 1'b0; cfg_err_i = 1'b0;
  endtask

  task automatic wait_fetch();
    int n;
    n = 0;
    while (!fetch_enable_o && n < 1000) begin
      n++;
      tick();
    end
    chk("start_dly", n, 20);
  endtask

  task automatic wait_not_busy();
    int n;
    n = 0;
    while (busy_o && n < 5000) begin
      n++;
      tick();
    end
    chk("finish_in_bound", {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    int  n;
    bit  seen;
    exp_t e;

    // Reset state
    repeat (3) tick();
    chk("rst_core_rst", {31'd0, core_rst_o}, 32'd1);
    chk("rst_fetch", {31'd0, fetch_enable_o}, 32'd0);
    chk("rst_req", {31'd0, cfg_req_o}, 32'd0);
    chk("rst_addr", cfg_addr_o, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_status", {30'd0, status_o}, 32'd0);
    chk("rst_cycles", cycles_o, 32'd0);
    rst = 1'b0; tick();

    // Pass: eoc raised during RUN cycle 1000, two sync stages of lag
    e.st = 2'b01; e.cyc = 32'd1002; exp_q.push_back(e);
    timeout_i = '0;
    start_and_cfg(1'b0, 3, 1'b0);
    wait_fetch();
    repeat (999) tick();
    eoc_i = 1'b1;
    wait_not_busy();
    eoc_i = 1'b0;
    chk("pass_status", {30'd0, status_o}, 32'd1);
    chk("pass_fetch_off", {31'd0, fetch_enable_o}, 32'd0);
    chk("pass_core_rst", {31'd0, core_rst_o}, 32'd0);
    repeat (5) tick();

    // Timeout after exactly 100 RUN cycles
    timeout_i = 24'd100;
    e.st = 2'b11; e.cyc = 32'd100; exp_q.push_back(e);
    start_and_cfg(1'b0, 3, 1'b0);
    wait_fetch();
    n = 0;
    while (fetch_enable_o && n < 1000) begin
      n++;
      tick();
    end
    chk("tout_run_len", n, 100);
    chk("tout_status", {30'd0, status_o}, 32'd3);
    repeat (3) tick();

    // Config error: fetch never enabled
    timeout_i = '0;
    e.st = 2'b10; e.cyc = 32'd0; exp_q.push_back(e);
    start_and_cfg(1'b1, 3, 1'b0);
    seen = 1'b0;
    repeat (30) begin
      if (fetch_enable_o) seen = 1'b1;
      tick();
    end
    chk("cerr_no_fetch", {31'd0, seen}, 32'd0);
    chk("cerr_status", {30'd0, status_o}, 32'd2);
    chk("cerr_busy", {31'd0, busy_o}, 32'd0);

    // Abort while request pending: bus completes, then IDLE
    start_and_cfg(1'b0, 10, 1'b1);
    chk("abort_req_busy", {31'd0, busy_o}, 32'd0);
    chk("abort_req_core_rst", {31'd0, core_rst_o}, 32'd1);
    chk("abort_req_status", {30'd0, status_o}, 32'd0);
    seen = 1'b0;
    repeat (30) begin
      if (fetch_enable_o || busy_o) seen = 1'b1;
      tick();
    end
    chk("abort_req_stays_idle", {31'd0, seen}, 32'd0);

    // Abort beats start in the same cycle
    start_i = 1'b1; abort_i = 1'b1; tick();
    start_i = 1'b0; abort_i = 1'b0;
    chk("abort_beats_start", {31'd0, busy_o}, 32'd0);

    // Abort from RUN
    start_and_cfg(1'b0, 2, 1'b0);
    wait_fetch();
    repeat (5) tick();
    abort_i = 1'b1; tick(); abort_i = 1'b0;
    chk("abort_run_busy", {31'd0, busy_o}, 32'd0);
    chk("abort_run_core_rst", {31'd0, core_rst_o}, 32'd1);
    chk("abort_run_fetch", {31'd0, fetch_enable_o}, 32'd0);

    // Reset mid-RUN
    start_and_cfg(1'b0, 1, 1'b0);
    wait_fetch();
    repeat (20) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_fetch", {31'd0, fetch_enable_o}, 32'd0);
    chk("midrst_core_rst", {31'd0, core_rst_o}, 32'd1);
    chk("midrst_status", {30'd0, status_o}, 32'd0);
    chk("midrst_cycles", cycles_o, 32'd0);
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    tick();

    // eoc and timeout land in the same cycle: pass wins
    timeout_i = 24'd12;
    e.st = 2'b01; e.cyc = 32'd12; exp_q.push_back(e);
    start_and_cfg(1'b0, 3, 1'b0);
    wait_fetch();
    repeat (9) tick();
    eoc_i = 1'b1;
    wait_not_busy();
    eoc_i = 1'b0;
    repeat (4) tick();

    // Same timeout without eoc
    e.st = 2'b11; e.cyc = 32'd12; exp_q.push_back(e);
    start_and_cfg(1'b0, 3, 1'b0);
    wait_fetch();
    wait_not_busy();
    repeat (3) tick();

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
